// File: rtl/jt49_permeter.sv
// jt49_permeter: period meter for JT49 square-wave channels.
//
// Counts clock-enable ticks between successive toggles of din and reports
// the interval in divider-period units. Fed by a tone/noise divider output
// it recovers the programmed period (P = 0 reads back as 1).
//
// Parameters:
//   W           counter / result width (matches divider period width)
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   cen         clock enable; sampling and counting only when high
//   clr         synchronous clear, highest priority, independent of cen
//   din         square wave to measure
//   period_out  last measured half-period in cen ticks
//   valid       one-clk pulse when period_out is updated
//   locked      last two measurements were equal
//   timeout     counter saturated with no edge
//
// Optional feature: define JT49_PERMETER_SYNC_EN to pass din through a
// 2-flop synchronizer (reset to 0) before edge detection, for asynchronous
// or off-chip sources. Undefined: din must be synchronous to clk.

module jt49_permeter #(
  parameter int unsigned W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cen,
  input  logic         clr,
  input  logic         din,
  output logic [W-1:0] period_out,
  output logic         valid,
  output logic         locked,
  output logic         timeout
);

  localparam logic [W-1:0] CntMax = {W{1'b1}};
  localparam logic [W-1:0] CntOne = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StMeas, StTout} state_e;

  logic din_src;

`ifdef JT49_PERMETER_SYNC_EN
  logic din_s1_q, din_s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_s1_q <= 1'b0;
      din_s2_q <= 1'b0;
    end else begin
      din_s1_q <= din;
      din_s2_q <= din_s1_q;
    end
  end

  assign din_src = din_s2_q;
`else
  assign din_src = din;
`endif

  state_e       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] period_q, period_d;
  logic         valid_q, valid_d;
  logic         locked_q, locked_d;
  logic         timeout_q, timeout_d;
  logic         have_prev_q, have_prev_d;
  logic         din_q, din_d;
  logic         edge_det;

  // Both polarities count as an edge, but only on sampled (cen) cycles.
  assign edge_det = cen && (din_src != din_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    period_d    = period_q;
    valid_d     = 1'b0;
    locked_d    = locked_q;
    timeout_d   = timeout_q;
    have_prev_d = have_prev_q;
    din_d       = din_q;

    if (clr) begin
      // Resample din so the cycle after a clear never sees a stale edge.
      state_d     = StIdle;
      cnt_d       = '0;
      period_d    = '0;
      locked_d    = 1'b0;
      timeout_d   = 1'b0;
      have_prev_d = 1'b0;
      din_d       = din_src;
    end else if (cen) begin
      din_d = din_src;

      if (edge_det) begin
        cnt_d = CntOne;
      end else if (cnt_q != CntMax) begin
        cnt_d = cnt_q + CntOne;
      end

      case (state_q)
        StIdle: begin
          if (edge_det) begin
            state_d = StMeas;
          end
        end
        StMeas: begin
          // An edge on the saturating tick still counts as a measurement.
          if (edge_det) begin
            period_d    = cnt_q;
            valid_d     = 1'b1;
            locked_d    = have_prev_q && (cnt_q == period_q);
            have_prev_d = 1'b1;
          end else if (cnt_q == CntMax) begin
            state_d     = StTout;
            timeout_d   = 1'b1;
            locked_d    = 1'b0;
            have_prev_d = 1'b0;
          end
        end
        StTout: begin
          // The interval that ends here is unbounded, so it is not reported.
          if (edge_det) begin
            state_d   = StMeas;
            timeout_d = 1'b0;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      period_q    <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
      have_prev_q <= 1'b0;
      din_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      timeout_q   <= timeout_d;
      have_prev_q <= have_prev_d;
      din_q       <= din_d;
    end
  end

  assign period_out = period_q;
  assign valid      = valid_q;
  assign locked     = locked_q;
  assign timeout    = timeout_q;

endmodule
